bbox_pio_sched: RTL
===================

# bbox_pio_sched

Round-robin scheduler that shares the single set of bounding-box PIO registers (x, y, width, height) read by the Nios II between NUM_REQ detection/tracking engines. Grants one requester at a time, holds its box stable until software acknowledges through a PIO write, then moves to the next requester. It sits between the vision datapath and the WiFi system's coordinate PIO inputs.

## Interface

Parameters:
- NUM_REQ, 4, number of requesting engines (≥2)
- COORD_W, 12, coordinate width, matching the PIO width
- TIMEOUT_CYCLES, 50000000, ack timeout in clocks (1 s at 50 MHz; used only with timeout enabled)
- SRC_W, derived localparam = $clog2(NUM_REQ)

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a box
- req_ready  out  NUM_REQ  one-hot accept strobe
- req_x, req_y, req_w, req_h  in  NUM_REQ*COORD_W  each  flattened boxes; requester i at [i*COORD_W +: COORD_W]
- pio_x, pio_y, pio_width, pio_height  out  COORD_W  box presented to software
- pio_src  out  SRC_W  index of the requester that owns the presented box
- pio_valid  out  1  presented box not yet consumed
- pio_ack  in  1  software ack level, same clock domain
- drop_count  out  8  saturating count of timed-out boxes

## Operation

- States: IDLE, HOLD.
- IDLE: if any req_valid, pick the first set bit searching from rr_ptr upward with wrap; assert req_ready for that index only, combinationally, in the same cycle. A transfer occurs when req_valid[i] & req_ready[i]. At that edge, capture the box and index into the pio_* registers, set pio_valid, go to HOLD, and set rr_ptr = (grant+1) mod NUM_REQ.
- HOLD: req_ready all zero; pio_* stable. On a rising edge of pio_ack (ack_q==0 && pio_ack==1, ack_q registered), clear pio_valid and go to IDLE.
- After release, pio_x/y/width/height/src keep their last values. They are not cleared.
- No requester is starved: a requester with valid held high is granted within NUM_REQ grants.
- Coordinates pass through unmodified. No arithmetic is applied to them.
- A pio_ack held high across a grant does not count as an ack. A new rising edge is required.

## Timing

- Reset (async assert, sync release): pio_* = 0, pio_src = 0, pio_valid = 0, req_ready = 0, rr_ptr = 0, ack_q = 0, drop_count = 0, state = IDLE.
- Grant latency: req_valid seen in IDLE at cycle N gives req_ready in cycle N and pio_valid = 1 with new data at N+1.
- Ack: rising edge sampled at cycle M gives pio_valid = 0 and state IDLE at M+1. The next grant can occur at M+1, with new data valid at M+2.
- Requesters must hold their data stable while req_valid is high and not yet accepted.
- Reset asserted in HOLD: the box is discarded and outputs go to reset values immediately.

## Configuration

- BBOX_TIMEOUT_EN defined:
  - A counter runs in HOLD, cleared on entry.
  - When it reaches TIMEOUT_CYCLES-1 without an ack rising edge, the block clears pio_valid, increments drop_count (saturating at 255), and returns to IDLE next cycle.
  - If the ack edge and the timeout occur in the same cycle, the ack wins and there is no drop.
- BBOX_TIMEOUT_EN undefined:
  - There is no counter. HOLD waits indefinitely.
  - drop_count is tied to 0.

## Structure

- Shared package bbox_pkg contains:
  - COORD_W default constant
  - bbox_t struct (x, y, w, h)
  - state enum (IDLE, HOLD)
- Sub-module rr_arbiter (parameter N):
  - inputs: req, ptr
  - output: one-hot grant, plus a grant index
  - purely combinational
- The top level holds the FSM, capture registers, ack edge detect and timeout counter.

## Test plan

- Reset, then only requester 2 valid with box (100,200,30,40): req_ready = 4'b0100 in the same cycle; next cycle pio_x = 100, pio_y = 200, pio_width = 30, pio_height = 40, pio_src = 2, pio_valid = 1.
- All four requesters valid continuously, software acking each box: pio_src sequence is 0,1,2,3,0. Each grant is at most 2 cycles after its ack edge.
- pio_ack held high through a grant: pio_valid stays 1 until ack drops and rises again.
- Requester 1 changes its inputs during HOLD: pio_* unchanged until the next grant.
- With BBOX_TIMEOUT_EN and TIMEOUT_CYCLES = 16, never ack: pio_valid drops after 16 HOLD cycles and drop_count goes 0→1. Running 300 timeouts leaves drop_count = 255. Ack edge on the 16th cycle leaves drop_count unchanged.
- Async reset pulse mid-HOLD: pio_valid = 0 and pio_* = 0 immediately. The first grant after release starts from requester 0.

Source files
------------

// File: rtl/bbox_pkg.sv
// Shared types for the bounding-box PIO scheduler: default coordinate width,
// box record and the two-state scheduler FSM encoding.
package bbox_pkg;
    localparam int BBOX_COORD_W = 12;

    typedef struct packed {
        logic [BBOX_COORD_W-1:0] x;
        logic [BBOX_COORD_W-1:0] y;
        logic [BBOX_COORD_W-1:0] w;
        logic [BBOX_COORD_W-1:0] h;
    } bbox_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Returns a one-hot grant and the matching index (index is 0 when nothing is requested).
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx
);
    logic found;
    int   j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end
endmodule

// File: rtl/bbox_pio_sched.sv
// Round-robin sharing of one bounding-box PIO register set between NUM_REQ engines.
// Optional ack timeout with saturating drop counter: define BBOX_TIMEOUT_EN.
module bbox_pio_sched
    import bbox_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int COORD_W        = BBOX_COORD_W,
    parameter int TIMEOUT_CYCLES = 50000000,
    localparam int SRC_W         = $clog2(NUM_REQ)
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*COORD_W-1:0] req_x,
    input  logic [NUM_REQ*COORD_W-1:0] req_y,
    input  logic [NUM_REQ*COORD_W-1:0] req_w,
    input  logic [NUM_REQ*COORD_W-1:0] req_h,
    output logic [COORD_W-1:0]         pio_x,
    output logic [COORD_W-1:0]         pio_y,
    output logic [COORD_W-1:0]         pio_width,
    output logic [COORD_W-1:0]         pio_height,
    output logic [SRC_W-1:0]           pio_src,
    output logic                       pio_valid,
    input  logic                       pio_ack,
    output logic [7:0]                 drop_count
);
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
    } box_t;

    state_e             state_q, state_d;
    box_t               box_q, box_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [SRC_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic               ack_q;
    logic [NUM_REQ-1:0] grant;
    logic [SRC_W-1:0]   gidx;
    logic               ack_rise;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx)
    );

    // Only a fresh rising edge releases the box; a level held across a grant does not.
    assign ack_rise = pio_ack & ~ack_q;

`ifdef BBOX_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       drop_q, drop_d;
`endif

    always_comb begin
        state_d   = state_q;
        box_d     = box_q;
        src_d     = src_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        req_ready = '0;
`ifdef BBOX_TIMEOUT_EN
        tmo_d     = tmo_q;
        drop_d    = drop_q;
`endif
        case (state_q)
            IDLE: begin
                req_ready = grant;
                if (|req_valid) begin
                    box_d.x = req_x[int'(gidx)*COORD_W +: COORD_W];
                    box_d.y = req_y[int'(gidx)*COORD_W +: COORD_W];
                    box_d.w = req_w[int'(gidx)*COORD_W +: COORD_W];
                    box_d.h = req_h[int'(gidx)*COORD_W +: COORD_W];
                    src_d   = gidx;
                    valid_d = 1'b1;
                    state_d = HOLD;
                    ptr_d   = (gidx == SRC_W'(NUM_REQ - 1)) ? '0 : gidx + SRC_W'(1);
`ifdef BBOX_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            HOLD: begin
                if (ack_rise) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
`ifdef BBOX_TIMEOUT_EN
                end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                    if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
            box_q   <= '0;
            src_q   <= '0;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            box_q   <= box_d;
            src_q   <= src_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            ack_q   <= pio_ack;
        end
    end

`ifdef BBOX_TIMEOUT_EN
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tmo_q  <= '0;
            drop_q <= '0;
        end else begin
            tmo_q  <= tmo_d;
            drop_q <= drop_d;
        end
    end
    assign drop_count = drop_q;
`else
    assign drop_count = 8'd0;
`endif

    assign pio_x      = box_q.x;
    assign pio_y      = box_q.y;
    assign pio_width  = box_q.w;
    assign pio_height = box_q.h;
    assign pio_src    = src_q;
    assign pio_valid  = valid_q;
endmodule
